// File: rtl/spi_register_bridge.sv
// SPI frame decoder: turns the secondary's byte stream into register-bank writes/reads
// and supplies the next MISO byte (status or read data) back to the shift register.
module spi_register_bridge #(
    parameter int DATA_BYTES = 4,
    parameter int ADDR_BITS  = 7
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cs,
    input  logic                    word_ready,
    input  logic [7:0]              data_word_received,
    output logic [7:0]              data_word_to_send,
    output logic                    wr_valid,
    input  logic                    wr_ready,
    output logic [ADDR_BITS-1:0]    wr_addr,
    output logic [8*DATA_BYTES-1:0] wr_data,
    output logic                    rd_strobe,
    output logic [ADDR_BITS-1:0]    rd_addr,
    input  logic [8*DATA_BYTES-1:0] rd_data
);

    localparam int DW = 8 * DATA_BYTES;
    localparam int CW = 3;
    localparam logic [CW-1:0] LAST_CNT = CW'(DATA_BYTES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_DATA,
        ST_RD_TURN,
        ST_RD_DATA,
        ST_DONE
    } state_t;

    state_t                state_q, state_d;
    logic                  cs_meta_q, cs_sync_q, cs_prev_q;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [ADDR_BITS-1:0]  cmd_addr_q, cmd_addr_d;
    logic [DW-1:0]         wr_shift_q, wr_shift_d;
    logic [DW-1:0]         rd_buf_q, rd_buf_d;
    logic                  rd_capture_q;
    logic [7:0]            tx_q, tx_d;
    logic                  wr_valid_q, wr_valid_d;
    logic [ADDR_BITS-1:0]  wr_addr_q, wr_addr_d;
    logic [DW-1:0]         wr_data_q, wr_data_d;
    logic                  rd_strobe_q, rd_strobe_d;
    logic [ADDR_BITS-1:0]  rd_addr_q, rd_addr_d;
    logic                  overflow_q, overflow_d;
    logic                  frame_error_q, frame_error_d;

    logic                  deselect, byte_valid, flag_clr, ovf_set, ferr_set;
    logic [7:0]            status;
    logic [DW-1:0]         shift_in;

    // cs resets to "deselected" so reset release never looks like a frame end
    assign deselect   = cs_sync_q & ~cs_prev_q;
    assign byte_valid = word_ready & ~cs_sync_q;
    assign status     = {wr_valid_q, overflow_q, frame_error_q, 5'b0};
    assign shift_in   = (wr_shift_q << 8) | DW'(data_word_received);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        cmd_addr_d    = cmd_addr_q;
        wr_shift_d    = wr_shift_q;
        rd_buf_d      = rd_buf_q;
        tx_d          = tx_q;
        wr_valid_d    = wr_valid_q;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        rd_strobe_d   = 1'b0;
        rd_addr_d     = rd_addr_q;
        flag_clr      = 1'b0;
        ovf_set       = 1'b0;
        ferr_set      = 1'b0;

        if (wr_valid_q && wr_ready) begin
            wr_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                tx_d  = status;
                cnt_d = '0;
                if (byte_valid) begin
                    flag_clr   = 1'b1;
                    cmd_addr_d = data_word_received[ADDR_BITS-1:0];
                    if (data_word_received[7]) begin
                        state_d = ST_WR_DATA;
                        tx_d    = 8'h00;
                    end else begin
                        state_d     = ST_RD_TURN;
                        rd_strobe_d = 1'b1;
                        rd_addr_d   = data_word_received[ADDR_BITS-1:0];
                    end
                end
            end
            ST_WR_DATA: begin
                if (byte_valid) begin
                    wr_shift_d = shift_in;
                    cnt_d      = cnt_q + 3'd1;
                    tx_d       = 8'h00;
                    if (cnt_q + 3'd1 == LAST_CNT) begin
                        state_d = ST_DONE;
                        if (wr_valid_q) begin
                            ovf_set = 1'b1;
                        end else begin
                            wr_valid_d = 1'b1;
                            wr_addr_d  = cmd_addr_q;
                            wr_data_d  = shift_in;
                        end
                    end
                end
            end
            ST_RD_TURN: begin
                // cnt counts read bytes already handed to the shift register
                if (rd_capture_q) begin
                    tx_d     = rd_data[DW-1 -: 8];
                    rd_buf_d = rd_data << 8;
                    cnt_d    = 3'd1;
                end
                if (byte_valid) begin
                    if (cnt_q >= LAST_CNT) begin
                        state_d = ST_DONE;
                    end else begin
                        tx_d     = rd_buf_q[DW-1 -: 8];
                        rd_buf_d = rd_buf_q << 8;
                        cnt_d    = cnt_q + 3'd1;
                        state_d  = (cnt_q + 3'd1 == LAST_CNT) ? ST_DONE : ST_RD_DATA;
                    end
                end
            end
            ST_RD_DATA: begin
                if (byte_valid) begin
                    tx_d     = rd_buf_q[DW-1 -: 8];
                    rd_buf_d = rd_buf_q << 8;
                    cnt_d    = cnt_q + 3'd1;
                    if (cnt_q + 3'd1 == LAST_CNT) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (byte_valid) begin
                    tx_d = 8'h00;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (deselect) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            if (state_q == ST_WR_DATA || state_q == ST_RD_TURN || state_q == ST_RD_DATA) begin
                ferr_set = 1'b1;
            end
        end

        overflow_d    = (overflow_q & ~flag_clr) | ovf_set;
        frame_error_d = (frame_error_q & ~flag_clr) | ferr_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cs_meta_q     <= 1'b1;
            cs_sync_q     <= 1'b1;
            cs_prev_q     <= 1'b1;
            cnt_q         <= '0;
            cmd_addr_q    <= '0;
            wr_shift_q    <= '0;
            rd_buf_q      <= '0;
            rd_capture_q  <= 1'b0;
            tx_q          <= 8'h00;
            wr_valid_q    <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            rd_strobe_q   <= 1'b0;
            rd_addr_q     <= '0;
            overflow_q    <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cs_meta_q     <= cs;
            cs_sync_q     <= cs_meta_q;
            cs_prev_q     <= cs_sync_q;
            cnt_q         <= cnt_d;
            cmd_addr_q    <= cmd_addr_d;
            wr_shift_q    <= wr_shift_d;
            rd_buf_q      <= rd_buf_d;
            rd_capture_q  <= rd_strobe_q;
            tx_q          <= tx_d;
            wr_valid_q    <= wr_valid_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            rd_strobe_q   <= rd_strobe_d;
            rd_addr_q     <= rd_addr_d;
            overflow_q    <= overflow_d;
            frame_error_q <= frame_error_d;
        end
    end

    assign data_word_to_send = tx_q;
    assign wr_valid          = wr_valid_q;
    assign wr_addr           = wr_addr_q;
    assign wr_data           = wr_data_q;
    assign rd_strobe         = rd_strobe_q;
    assign rd_addr           = rd_addr_q;

endmodule

// File: tb/tb_spi_register_bridge.sv
// Scoreboard bench for spi_register_bridge: stimulus pushes expected MISO bytes,
// writes and read addresses; one monitor process pops and compares them.
module tb_spi_register_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cs = 1'b1;
    logic        word_ready = 1'b0;
    logic [7:0]  data_word_received = 8'h00;
    logic [7:0]  data_word_to_send;
    logic        wr_valid;
    logic        wr_ready = 1'b0;
    logic [6:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rd_strobe;
    logic [6:0]  rd_addr;
    logic [31:0] rd_data = 32'h01234567;

    logic        sof = 1'b0;
    logic        rst_chk = 1'b0;
    logic        end_chk = 1'b0;

    logic [7:0]  exp_miso[$];
    logic [38:0] exp_wr[$];
    logic [6:0]  exp_rd[$];
    int          total = 0;
    int          bad = 0;

    spi_register_bridge #(.DATA_BYTES(4), .ADDR_BITS(7)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .cs                 (cs),
        .word_ready         (word_ready),
        .data_word_received (data_word_received),
        .data_word_to_send  (data_word_to_send),
        .wr_valid           (wr_valid),
        .wr_ready           (wr_ready),
        .wr_addr            (wr_addr),
        .wr_data            (wr_data),
        .rd_strobe          (rd_strobe),
        .rd_addr            (rd_addr),
        .rd_data            (rd_data)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // single monitor process: all comparisons happen here
    initial forever begin
        @(negedge clk);
        if (rst_chk) begin
            check("rst_miso", 64'(data_word_to_send), 64'h0);
            check("rst_wr_valid", 64'(wr_valid), 64'h0);
            check("rst_wr_addr", 64'(wr_addr), 64'h0);
            check("rst_wr_data", 64'(wr_data), 64'h0);
            check("rst_rd_strobe", 64'(rd_strobe), 64'h0);
            check("rst_rd_addr", 64'(rd_addr), 64'h0);
        end
        if (rst_n) begin
            if (sof || word_ready) begin
                if (exp_miso.size() == 0) begin
                    total++; bad++;
                    $display("FAIL miso_unexpected: got=%0h expected=none", data_word_to_send);
                end else begin
                    automatic logic [7:0] e = exp_miso.pop_front();
                    check("miso", 64'(data_word_to_send), 64'(e));
                end
            end
            if (wr_valid && wr_ready) begin
                if (exp_wr.size() == 0) begin
                    total++; bad++;
                    $display("FAIL wr_unexpected: got=%0h_%0h expected=none", wr_addr, wr_data);
                end else begin
                    automatic logic [38:0] w = exp_wr.pop_front();
                    check("wr_txn", 64'({wr_addr, wr_data}), 64'(w));
                end
            end
            if (rd_strobe) begin
                if (exp_rd.size() == 0) begin
                    total++; bad++;
                    $display("FAIL rd_unexpected: got=%0h expected=none", rd_addr);
                end else begin
                    automatic logic [6:0] a = exp_rd.pop_front();
                    check("rd_addr", 64'(rd_addr), 64'(a));
                end
            end
        end
        if (end_chk) begin
            check("miso_left", 64'(exp_miso.size()), 64'h0);
            check("wr_left", 64'(exp_wr.size()), 64'h0);
            check("rd_left", 64'(exp_rd.size()), 64'h0);
            check("end_wr_valid", 64'(wr_valid), 64'h0);
        end
    end

    task automatic send_byte(input logic [7:0] b);
        repeat (30) @(posedge clk);
        #1 word_ready = 1'b1;
        data_word_received = b;
        @(posedge clk);
        #1 word_ready = 1'b0;
    endtask

    // rx[0] is the byte presented at frame start, rx[k+1] the byte held during tx[k]'s strobe
    task automatic run_frame(input logic [7:0] tx[$], input logic [7:0] rx[$], input bit hold_cs);
        foreach (rx[i]) exp_miso.push_back(rx[i]);
        @(posedge clk);
        #1 cs = 1'b0;
        repeat (4) @(posedge clk);
        #1 sof = 1'b1;
        @(posedge clk);
        #1 sof = 1'b0;
        foreach (tx[i]) send_byte(tx[i]);
        if (!hold_cs) begin
            repeat (2) @(posedge clk);
            #1 cs = 1'b1;
            repeat (6) @(posedge clk);
        end
    endtask

    initial begin
        logic [7:0] tx[$];
        logic [7:0] rx[$];

        repeat (3) @(posedge clk);
        #1 rst_chk = 1'b1;
        @(posedge clk);
        #1 rst_chk = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // plain write, accepted at once
        #1 wr_ready = 1'b1;
        tx = '{8'h85, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        rx = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        exp_wr.push_back({7'h05, 32'hDEADBEEF});
        run_frame(tx, rx, 1'b0);

        // plain read
        tx = '{8'h12, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        rx = '{8'h00, 8'h00, 8'h01, 8'h23, 8'h45, 8'h67, 8'h00};
        exp_rd.push_back(7'h12);
        run_frame(tx, rx, 1'b0);

        // back-pressure: second write dropped, overflow reported then cleared
        #1 wr_ready = 1'b0;
        tx = '{8'h81, 8'h11, 8'h22, 8'h33, 8'h44};
        rx = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_frame(tx, rx, 1'b0);
        tx = '{8'h82, 8'h55, 8'h66, 8'h77, 8'h88};
        rx = '{8'h80, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00};
        run_frame(tx, rx, 1'b0);
        tx = '{8'h12, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        rx = '{8'hC0, 8'hC0, 8'h01, 8'h23, 8'h45, 8'h67, 8'h00};
        exp_rd.push_back(7'h12);
        run_frame(tx, rx, 1'b0);
        #1 rd_data = 32'hA5C30F96;
        tx = '{8'h7F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        rx = '{8'h80, 8'h80, 8'hA5, 8'hC3, 8'h0F, 8'h96, 8'h00};
        exp_rd.push_back(7'h7F);
        run_frame(tx, rx, 1'b0);
        exp_wr.push_back({7'h01, 32'h11223344});
        @(posedge clk);
        #1 wr_ready = 1'b1;
        repeat (4) @(posedge clk);

        // truncated write: discarded, frame_error reported once
        tx = '{8'h85, 8'h01, 8'h02};
        rx = '{8'h00, 8'h00, 8'h00, 8'h00};
        run_frame(tx, rx, 1'b0);
        tx = '{8'h83, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
        rx = '{8'h20, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00};
        exp_wr.push_back({7'h03, 32'hCAFEBABE});
        run_frame(tx, rx, 1'b0);

        // status clean again; six trailing bytes are ignored
        tx = '{8'h84, 8'h01, 8'h02, 8'h03, 8'h04, 8'hFF, 8'h00, 8'h55, 8'hAA, 8'h12, 8'h34};
        rx = '{};
        for (int i = 0; i < 12; i++) rx.push_back(8'h00);
        exp_wr.push_back({7'h04, 32'h01020304});
        run_frame(tx, rx, 1'b0);

        // reset in the middle of read data shifting
        #1 rd_data = 32'h01234567;
        tx = '{8'h12, 8'h00, 8'h00};
        rx = '{8'h00, 8'h00, 8'h01, 8'h23};
        exp_rd.push_back(7'h12);
        run_frame(tx, rx, 1'b1);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        rst_chk = 1'b1;
        @(posedge clk);
        #1 rst_chk = 1'b0;
        cs = 1'b1;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);

        tx = '{8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        rx = '{8'h00, 8'h00, 8'h01, 8'h23, 8'h45, 8'h67, 8'h00};
        exp_rd.push_back(7'h33);
        run_frame(tx, rx, 1'b0);

        @(posedge clk);
        #1 end_chk = 1'b1;
        @(posedge clk);
        #1 end_chk = 1'b0;
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
